disp_signed_bcd: RTL and testbench
==================================

DISP_SIGNED_BCD -- requirements
Module: disp_signed_bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the two's-complement input width (legal range 2..16).
REQ-002 SHALL have parameter NDIGITS, default 4, meaning the number of 7-segment displays driven (legal range 2..6).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, a conversion request sampled in IDLE.
REQ-006 SHALL have port x, input, WIDTH bits, the signed two's-complement value sampled with start.
REQ-007 SHALL have port enable, input, 1 bit; 0 blanks all displays combinationally without disturbing stored results.
REQ-008 SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle pulse when new segments are valid.
REQ-010 SHALL have port overflow, output, 1 bit, high when the last result did not fit in NDIGITS.
REQ-011 SHALL have port segs, output, NDIGITS*7 bits; digit i occupies [7i+6:7i]; digit 0 is rightmost; active-low; bit 0 is segment a and bit 6 is segment g.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and FORMAT.
REQ-013 SHALL, in IDLE with start=1 at edge k, latch sign=x[WIDTH-1] and magnitude |x| in WIDTH+1 bits (most-negative value exact), clear BCD, and go to SHIFT.
REQ-014 SHALL, in SHIFT, perform one double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift in the magnitude MSB) for exactly WIDTH+1 cycles, using a down-counter.
REQ-015 SHALL, in FORMAT, register segs/overflow at one edge, pulse done for the following cycle, and return to IDLE; done edge = k+WIDTH+3.
REQ-016 SHALL hold busy=1 from the cycle after edge k until done asserts; busy=0 while done=1.
REQ-017 SHALL ignore start while busy; start coincident with done SHALL NOT be accepted (accepted next cycle if held).
REQ-018 SHALL blank leading zeros; value 0 SHALL show "0" on digit 0 only.
REQ-019 SHALL, for negative values, place minus (segment g only) in the digit immediately left of the most-significant nonzero digit.
REQ-020 SHALL set overflow=1 when significant digits plus sign exceed NDIGITS, and SHALL show minus on all digits in that case.
REQ-021 SHALL keep segs and overflow stable between done pulses.
REQ-022 SHALL size the BCD register at ceil((WIDTH+1)*log10(2)) digits plus one, so no intermediate value is truncated.

Reset
REQ-023 SHALL, on rst=1 at any time (including mid-SHIFT), force IDLE with busy=0, done=0, overflow=0, segs all-blank (all ones), and counter/BCD cleared.
REQ-024 SHALL, after rst deasserts, accept start on the first rising edge.

Structure
REQ-025 SHALL place segment constants SEG_BLANK (7'h7F), SEG_MINUS, and the FSM state typedef in shared package disp_pkg.
REQ-026 SHALL instantiate sub-module bcd_to_sseg (4-bit BCD to active-low 7 segments) once per digit, generated over NDIGITS.
REQ-027 SHALL be fully parametric with no hard-coded WIDTH or NDIGITS values.

Verification
REQ-028 SHALL verify W=8,N=4: x=-128, start at edge 0 -> done at edge 11, segs "-128", overflow=0.
REQ-029 SHALL verify W=8,N=4: x=5 -> "   5"; x=0 -> "   0"; x=-7 -> "  -7"; x=127 -> " 127".
REQ-030 SHALL verify W=8,N=3: x=-128 -> overflow=1, all digits minus; then x=99 -> " 99", overflow=0.
REQ-031 SHALL verify a start pulse at edge 3 of an active conversion is ignored: a single done, result of the first x.
REQ-032 SHALL verify rst asserted mid-SHIFT -> immediate blank segs, busy=0, no done; next start converts correctly.
REQ-033 SHALL verify enable=0 -> all segs 7'h7F while a conversion completes; enable=1 -> new value shown without restart.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and types for the signed BCD seven-segment display block.
package disp_pkg;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_t;

  // Decimal digits needed for an unsigned value of 'bits' bits, plus one spare
  // digit so the double-dabble shift never drops a carry.
  // ceil(bits * log10(2)) is evaluated in fixed point (log10(2) ~ 0.30103).
  function automatic int bcd_digits(input int bits);
    return (bits * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// One BCD nibble to an active-low seven-segment pattern; non-decimal codes blank.
module bcd_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup of the glyph for one decimal digit.
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_signed_bcd.sv
// Signed two's-complement to multi-digit seven-segment display driver.
// A start request latches sign and magnitude, a double-dabble loop converts the
// magnitude to BCD one bit per cycle, and a final cycle formats the digits
// (leading-zero blanking, minus placement, overflow) into a held segment register.
module disp_signed_bcd
  import disp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic                 enable,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [NDIGITS*7-1:0] segs
);

  // Magnitude carries one extra bit so the most-negative input is exact.
  localparam int MW = WIDTH + 1;
  localparam int NB = bcd_digits(MW);
  localparam int BW = 4 * NB;
  localparam int CW = $clog2(MW + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MW);

  state_t               state, state_next;
  logic                 sign_q;
  logic [MW-1:0]        mag_q;
  logic [MW-1:0]        mag_x;
  logic [BW-1:0]        bcd_q;
  logic [BW-1:0]        bcd_adj;
  logic [CW-1:0]        cnt_q;
  logic                 accept;
  logic                 done_q;
  logic                 overflow_q;
  logic                 ovf_next;
  logic [NDIGITS*7-1:0] segs_q;
  logic [NDIGITS*7-1:0] segs_next;
  logic [6:0]           dig_seg [NDIGITS];
  int                   nsig;

  // A start arriving in the done cycle is held off until the next cycle.
  assign accept = (state == IDLE) && start && !done_q;

  // Sign-extend, then negate when negative: -2^(WIDTH-1) becomes +2^(WIDTH-1).
  assign mag_x = x[WIDTH-1] ? (~{x[WIDTH-1], x} + MW'(1)) : {1'b0, x};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: SHIFT runs until the down-counter reaches its last step.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_next = FORMAT;
      FORMAT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    busy = (state != IDLE);
  end

  // Double-dabble correction: any nibble of 5 or more gets 3 added before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath and held display results.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    if (rst) begin
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      segs_q     <= {NDIGITS{SEG_BLANK}};
    end else begin
      done_q <= (state == FORMAT);
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= x[WIDTH-1];
            mag_q  <= mag_x;
            bcd_q  <= '0;
            cnt_q  <= CNT_LOAD;
          end
        end
        SHIFT: begin
          // The top bit shifted out is always zero thanks to the spare digit.
          bcd_q <= BW'({bcd_adj, mag_q[MW-1]});
          mag_q <= {mag_q[MW-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
        end
        FORMAT: begin
          segs_q     <= segs_next;
          overflow_q <= ovf_next;
        end
        default: ;
      endcase
    end
  end

  // One glyph decoder per display; displays beyond the BCD width see zero.
  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    logic [3:0] nib;
    if (g < NB) begin : g_src
      assign nib = bcd_q[4*g +: 4];
    end else begin : g_pad
      assign nib = 4'd0;
    end
    bcd_to_sseg u_dec (
      .bcd (nib),
      .seg (dig_seg[g])
    );
  end

  // Formatting: blank leading zeros, minus just left of the top digit, all
  // minus when digits plus sign do not fit.
  always_comb begin
    nsig = 1;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) nsig = i + 1;
    end
    ovf_next  = (nsig + (sign_q ? 1 : 0)) > NDIGITS;
    segs_next = {NDIGITS{SEG_BLANK}};
    for (int i = 0; i < NDIGITS; i++) begin
      if (ovf_next)                 segs_next[7*i +: 7] = SEG_MINUS;
      else if (i < nsig)            segs_next[7*i +: 7] = dig_seg[i];
      else if (sign_q && i == nsig) segs_next[7*i +: 7] = SEG_MINUS;
    end
  end

  assign done     = done_q;
  assign overflow = overflow_q;
  assign segs     = enable ? segs_q : {NDIGITS{SEG_BLANK}};

endmodule

// File: tb/tb_disp_signed_bcd.sv
// Directed bench for disp_signed_bcd: a 4-digit and a 3-digit instance, WIDTH=8.
// Outputs are sampled on the falling edge; cycle n is the falling edge just
// before rising edge n, counting the start-accepting edge as edge 0.
module tb_disp_signed_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start4, start3;
  logic [7:0]  x4, x3;
  logic        busy4, done4, ovf4;
  logic        busy3, done3, ovf3;
  logic [27:0] segs4;
  logic [20:0] segs3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  disp_signed_bcd #(.WIDTH(8), .NDIGITS(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (start4),
    .x        (x4),
    .enable   (en),
    .busy     (busy4),
    .done     (done4),
    .overflow (ovf4),
    .segs     (segs4)
  );

  disp_signed_bcd #(.WIDTH(8), .NDIGITS(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .start    (start3),
    .x        (x3),
    .enable   (en),
    .busy     (busy3),
    .done     (done3),
    .overflow (ovf3),
    .segs     (segs3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Hand-written active-low glyphs, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "0": return 7'h40;
      "1": return 7'h79;
      "2": return 7'h24;
      "3": return 7'h30;
      "4": return 7'h19;
      "5": return 7'h12;
      "6": return 7'h02;
      "7": return 7'h78;
      "8": return 7'h00;
      "9": return 7'h10;
      "-": return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Right-aligned display text to a 4-digit segment word (digit 0 = last char).
  function automatic logic [27:0] show(input string s);
    logic [27:0] r;
    int idx;
    r = '1;
    for (int i = 0; i < 4; i++) begin
      idx = s.len() - 1 - i;
      if (idx >= 0) r[7*i +: 7] = glyph(s[idx]);
    end
    return r;
  endfunction

  // Issue a start at the current falling edge and wait for done on the chosen
  // instance; checks busy, done latency (edge 11), busy low with done, one-cycle done.
  task automatic convert(input logic [7:0] v, input bit on3, input string tag);
    int cyc;
    if (on3) begin start3 = 1'b1; x3 = v; end
    else     begin start4 = 1'b1; x4 = v; end
    @(negedge clk);
    start3 = 1'b0;
    start4 = 1'b0;
    cyc = 1;
    check({tag, " busy after start"}, 32'(on3 ? busy3 : busy4), 32'd1);
    while (!(on3 ? done3 : done4) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " done edge"}, 32'(cyc), 32'd11);
    check({tag, " busy with done"}, 32'(on3 ? busy3 : busy4), 32'd0);
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(on3 ? done3 : done4), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int first_done;
    logic [27:0] held;

    rst = 1'b1; en = 1'b1;
    start4 = 1'b0; start3 = 1'b0; x4 = '0; x3 = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset segs4", 32'(segs4), 32'h0FFF_FFFF);
    check("reset segs3", 32'(segs3), 32'h001F_FFFF);
    check("reset busy4", 32'(busy4), 32'd0);
    check("reset done4", 32'(done4), 32'd0);
    check("reset ovf4",  32'(ovf4),  32'd0);

    // Start on the first rising edge after reset release.
    rst = 1'b0;
    convert(8'h80, 1'b0, "n4 -128");
    check("n4 -128 segs", 32'(segs4), 32'(show("-128")));
    check("n4 -128 ovf",  32'(ovf4),  32'd0);

    convert(8'd5, 1'b0, "n4 5");
    check("n4 5 segs", 32'(segs4), 32'(show("5")));
    convert(8'd0, 1'b0, "n4 0");
    check("n4 0 segs", 32'(segs4), 32'(show("0")));
    convert(8'hF9, 1'b0, "n4 -7");
    check("n4 -7 segs", 32'(segs4), 32'(show("-7")));
    convert(8'd127, 1'b0, "n4 127");
    check("n4 127 segs", 32'(segs4), 32'(show("127")));
    check("n4 127 ovf",  32'(ovf4),  32'd0);

    // Three-digit instance: overflow, then a value that fits.
    convert(8'h80, 1'b1, "n3 -128");
    check("n3 -128 ovf",  32'(ovf3),  32'd1);
    check("n3 -128 segs", 32'(segs3), 32'h001F_FFFF & 32'(show("---")));
    convert(8'd99, 1'b1, "n3 99");
    check("n3 99 ovf",  32'(ovf3),  32'd0);
    check("n3 99 segs", 32'(segs3), 32'h001F_FFFF & 32'(show("99")));

    // A second start at edge 3 of a running conversion is ignored.
    start4 = 1'b1; x4 = 8'd42;
    @(negedge clk);
    start4 = 1'b0;
    ndone = 0;
    first_done = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done4) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
      start4 = (c == 3);
      if (c == 3) x4 = 8'hF6;
      @(negedge clk);
    end
    check("ignored start done count", 32'(ndone), 32'd1);
    check("ignored start done edge",  32'(first_done), 32'd11);
    check("ignored start segs", 32'(segs4), 32'(show("42")));

    // Reset in the middle of SHIFT.
    start4 = 1'b1; x4 = 8'd77;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst segs", 32'(segs4), 32'h0FFF_FFFF);
    check("mid rst busy", 32'(busy4), 32'd0);
    check("mid rst done", 32'(done4), 32'd0);
    check("mid rst ovf",  32'(ovf4),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("mid rst no done", 32'(ndone), 32'd0);
    convert(8'hDF, 1'b0, "n4 -33");
    check("n4 -33 segs", 32'(segs4), 32'(show("-33")));

    // Enable low blanks while a conversion completes; enable high reveals it.
    en = 1'b0;
    convert(8'd64, 1'b0, "n4 64 dark");
    check("dark segs", 32'(segs4), 32'h0FFF_FFFF);
    repeat (2) @(negedge clk);
    en = 1'b1;
    #1;
    check("lit segs", 32'(segs4), 32'(show("64")));
    check("lit busy", 32'(busy4), 32'd0);
    held = segs4;
    repeat (5) @(negedge clk);
    check("held segs", 32'(segs4), 32'(held));
    check("held ovf",  32'(ovf4),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
